// File: rtl/div_seq_if.sv
// Request/response bundle between the EX stage (master) and the iterative divider (slave).
interface div_seq_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_seq.sv
// 32-step restoring shift-subtract divider for DIV/DIVU; returns {remainder, quotient}.
//  state   | meaning
//  FREE    | idle, waiting for start_i
//  DIVZERO | divisor was zero, result of 0 posted next edge
//  ON      | one restoring iteration per cycle, 32 cycles
//  END     | result held with ready_o until start_i drops
module div_seq (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    localparam logic [1:0] S_FREE    = 2'b00;
    localparam logic [1:0] S_DIVZERO = 2'b01;
    localparam logic [1:0] S_ON      = 2'b10;
    localparam logic [1:0] S_END     = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic [64:0] step_w;
    logic [31:0] quot_fin;
    logic [31:0] rem_fin;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        shifted  = work_q << 1;
        diff     = shifted[64:32] - {1'b0, divisor_q};
        fits     = shifted[64:32] >= {1'b0, divisor_q};
        step_w   = fits ? {diff, shifted[31:1], 1'b1} : shifted;
        quot_fin = neg_quot_q ? (32'd0 - step_w[31:0])  : step_w[31:0];
        rem_fin  = neg_rem_q  ? (32'd0 - step_w[63:32]) : step_w[63:32];

        a_neg = bus.signed_div_i & bus.opdata1_i[31];
        b_neg = bus.signed_div_i & bus.opdata2_i[31];
        // 0x80000000 negates to itself, which is the right unsigned magnitude
        abs_a = a_neg ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
        abs_b = b_neg ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        if (bus.annul_i) begin
            state_d  = S_FREE;
            ready_d  = 1'b0;
            result_d = 64'd0;
        end else begin
            case (state_q)
                S_FREE: begin
                    if (bus.start_i) begin
                        neg_quot_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        if (bus.opdata2_i == 32'd0) begin
                            state_d = S_DIVZERO;
                        end else begin
                            divisor_d = abs_b;
                            work_d    = {33'd0, abs_a};
                            cnt_d     = 5'd0;
                            state_d   = S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    state_d  = S_END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
                S_ON: begin
                    work_d = step_w;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_END;
                        result_d = {rem_fin, quot_fin};
                        ready_d  = 1'b1;
                    end
                end
                S_END: begin
                    if (!bus.start_i) begin
                        state_d  = S_FREE;
                        ready_d  = 1'b0;
                        result_d = 64'd0;
                    end
                end
                default: begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FREE;
            cnt_q      <= 5'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq: table of divisions plus annul and reset sequences.
module tb_div_seq;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_seq_if bus ();

    div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Cycle 0 is the cycle whose closing edge captures the request.
    task automatic run_div(input string name, input vec_t v);
        @(negedge clk);
        bus.signed_div_i = v.sgn;
        bus.opdata1_i    = v.a;
        bus.opdata2_i    = v.b;
        bus.start_i      = 1'b1;
        for (int k = 1; k <= v.lat; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~v.sgn;
            end
            if (k == v.lat - 1) begin
                check1({name, " ready_early"}, bus.ready_o, 1'b0);
                check64({name, " result_early"}, bus.result_o, 64'd0);
            end
        end
        check1({name, " ready"}, bus.ready_o, 1'b1);
        check64({name, " result"}, bus.result_o, v.exp);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check1({name, " ready_drop"}, bus.ready_o, 1'b0);
        check64({name, " result_drop"}, bus.result_o, 64'd0);
    endtask

    vec_t vecs[13];
    vec_t v;
    logic seen;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,          64'h0,                 2};
        vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'h0,                 2};
        vecs[7]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 33};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
        vecs[9]  = '{1'b0, 32'd7,          32'd100,        64'h00000007_00000000, 33};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33};
        vecs[11] = '{1'b0, 32'h80000000,   32'd2,          64'h00000000_40000000, 33};
        vecs[12] = '{1'b1, 32'h80000000,   32'd2,          64'h00000000_C0000000, 33};

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset ready", bus.ready_o, 1'b0);
        check64("reset result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i]);
        end

        // Annul mid-division: nothing may come back, then the unit must be reusable.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        check1("annul ready", bus.ready_o, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) seen = 1'b1;
        end
        check1("annul no_ready", seen, 1'b0);
        v = '{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33};
        run_div("after_annul", v);

        // Annul while holding a result with start still high.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd20;
        bus.opdata2_i    = 32'd0;
        bus.start_i      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check1("end_hold ready", bus.ready_o, 1'b1);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        check1("annul_end ready", bus.ready_o, 1'b0);
        repeat (2) @(posedge clk);

        // Asynchronous reset during ON, then during END.
        @(negedge clk);
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check1("rst_on ready", bus.ready_o, 1'b0);
        check64("rst_on result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        v = '{1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33};
        run_div("after_rst", v);

        @(negedge clk);
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i   = 1'b1;
        repeat (33) @(posedge clk);
        #2;
        check1("pre_rst_end ready", bus.ready_o, 1'b1);
        rst = 1'b0;
        #1;
        check1("rst_end ready", bus.ready_o, 1'b0);
        check64("rst_end result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle iterative divider serving the execute stage's DIV/DIVU requests. Takes the operands, signedness and start request that EX drives while it holds the pipeline stalled. Runs a 32-step restoring shift-subtract sequence and returns a 64-bit {remainder, quotient} with a ready flag. The EX stage writes that result to HI/LO. An annul input lets the pipeline abort an in-flight division on flush.

## Interface
Parameters: none; data width fixed at 32 bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled on accept only
- opdata1_i  in  32  dividend; sampled on accept only
- opdata2_i  in  32  divisor; sampled on accept only
- start_i  in  1  level request from EX; held high until EX has seen ready_o
- annul_i  in  1  abort current division (pipeline flush)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1, else 0
- ready_o  out  1  result valid

## Operation
- **States:** FREE, DIVZERO, ON, END. Registered outputs; reset state FREE, result_o = 0, ready_o = 0, iteration counter = 0.
- **Priority each edge:** rst, then annul_i, then normal transitions.
  - annul_i = 1 in any state: go to FREE, ready_o = 0, result_o = 0. No capture occurs even if start_i = 1 that edge.
- **FREE:** if start_i = 1 and annul_i = 0, latch signed_div_i.
  - Divisor = 0: go to DIVZERO.
  - Otherwise: latch |dividend| and |divisor|, with absolute value taken only when signed and the operand is negative.
  - Load the working register with {33'b0, |dividend|}, set the counter to 0 and go to ON.
  - Record the quotient sign (dividend[31] XOR divisor[31]) and the remainder sign (dividend[31]), both gated by signed.
- **DIVZERO:** next edge go to END with result_o = 64'h0 and ready_o = 1.
- **ON:** one iteration per cycle.
  - Shift the 65-bit working register left by 1.
  - If upper 33 bits ≥ {1'b0, |divisor|}: subtract the divisor from the upper bits and set bit 0.
  - Increment the counter.
- **Leaving ON:** on the iteration with counter = 31, go to END.
  - Register the quotient as the low 32 bits of the working register, two's-complemented if the quotient sign is set.
  - Register the remainder as bits [63:32] after the final step, two's-complemented if the remainder sign is set.
  - Set ready_o = 1.
- **start_i while busy:** ignored in ON/DIVZERO. Operand inputs are don't-care after accept.
- **END:** hold result_o and ready_o.
  - start_i = 0: go to FREE and clear ready_o and result_o.
  - start_i = 1: stay in END.
- **Arithmetic:**
  - |0x80000000| = 0x80000000 as unsigned. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no exception).
  - All negation is modulo 2^32.
  - Remainder magnitude is always < |divisor|.

## Timing
- Cycle 0 = first cycle start_i = 1 seen in FREE (capture at end of cycle 0).
- **Nonzero divisor:** ON in cycles 1–32; ready_o = 1 from cycle 33; latency 33 cycles.
- **Zero divisor:** DIVZERO in cycle 1; ready_o = 1 from cycle 2.
- **Back-to-back:** EX drops start_i in the cycle ready_o is seen. Next edge returns to FREE, so ready_o = 0 one cycle later. A new start_i is accepted no earlier than the cycle after returning to FREE.
- **annul_i:** takes effect at the edge it is sampled. ready_o = 0 in the following cycle.
- **rst asserted mid-operation:** outputs go to 0 immediately (asynchronous). Deassertion resumes in FREE.

## Test plan
- Unsigned 100 / 7, start held -> ready_o rises in cycle 33, result_o = 0x00000002_0000000E. Drop start -> ready_o = 0 next cycle.
- Signed 0xFFFFFFF9 (-7) / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). Signed 7 / -2 -> 0x00000001_FFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- Divisor 0 (either signedness) -> ready_o in cycle 2, result_o = 0.
- Start 100/7, pulse annul_i in cycle 10 -> ready_o never rises, block in FREE. Then:
  - Start 9/3 -> 0x00000000_00000003 at 33 cycles after its cycle 0.
  - Operand inputs changed during ON -> no effect on result.
- Assert rst in cycle 20 of a division -> ready_o/result_o 0 immediately. After release, new 50/5 -> 0x00000000_0000000A with normal latency.
